// File: rtl/ram_stream_reader.sv
// Burst reader: fetches length+1 consecutive words from a registered-output RAM
// and streams them out over an AXI-Stream style master through a 2-entry FIFO.
module ram_stream_reader #(
    parameter int unsigned RAM_DEPTH  = 1,
    parameter int unsigned BYTE_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     start_addr,
    input  logic [ADDR_WIDTH-1:0]     length,
    output logic                      busy,
    output logic                      done,
    output logic                      ram_rd_en,
    output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
    input  logic [BYTE_WIDTH*8-1:0]   ram_rd_data,
    output logic [BYTE_WIDTH*8-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);

    localparam int unsigned DATA_WIDTH = BYTE_WIDTH * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   nxt_addr_q, nxt_addr_d;
    logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
    logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]   beats_q, beats_d;
    logic                    pend_q;
    logic [1:0]              cnt_q, cnt_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   fifo_q [2];
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    pop_c;
    logic                    rd_en_c;
    logic [ADDR_WIDTH-1:0]   addr_inc_c;

    // Stream side is a direct view of the FIFO head
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = fifo_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && (beats_q == '0);
    assign pop_c         = m_axis_tvalid && m_axis_tready;

    // Credit check: stored + in-flight words after this cycle's pop must leave room
    assign rd_en_c = (state_q == READ) &&
                     ((3'({1'b0, cnt_q}) + 3'(pend_q)) < (3'd2 + 3'(pop_c)));

    assign addr_inc_c = (nxt_addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0
                                                                   : nxt_addr_q + ADDR_WIDTH'(1);

    assign ram_rd_en   = rd_en_c;
    assign ram_rd_addr = rd_en_c ? nxt_addr_q : last_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Next-state and control
    always_comb begin
        state_d     = state_q;
        nxt_addr_d  = nxt_addr_q;
        last_addr_d = last_addr_q;
        rem_d       = rem_q;
        beats_d     = beats_q;
        done_d      = 1'b0;

        if (pop_c && (beats_q != '0)) begin
            beats_d = beats_q - ADDR_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = READ;
                    nxt_addr_d = start_addr;
                    rem_d      = length;
                    beats_d    = length;
                end
            end
            READ: begin
                if (rd_en_c) begin
                    last_addr_d = nxt_addr_q;
                    nxt_addr_d  = addr_inc_c;
                    if (rem_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        rem_d = rem_q - ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop_c && m_axis_tlast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        cnt_d    = cnt_q + 2'(pend_q) - 2'(pop_c);
        wr_ptr_d = pend_q ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_c  ? ~rd_ptr_q : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            nxt_addr_q  <= '0;
            last_addr_q <= '0;
            rem_q       <= '0;
            beats_q     <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nxt_addr_q  <= nxt_addr_d;
            last_addr_q <= last_addr_d;
            rem_q       <= rem_d;
            beats_q     <= beats_d;
            pend_q      <= rd_en_c;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // RAM data arrives the cycle after the read enable and is captured here
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else if (pend_q) begin
            fifo_q[wr_ptr_q] <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: directed table, random bursts
// against a queue-based reference, and a mid-burst reset sequence.
module tb_ram_stream_reader;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned BW    = 1;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = BW * 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] length;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    ram_stream_reader #(
        .RAM_DEPTH (DEPTH),
        .BYTE_WIDTH(BW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .start_addr   (start_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

    always #5 clk = ~clk;

    // Registered-output RAM model
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    int checks    = 0;
    int failures  = 0;
    bit pend_done = 1'b0;

    typedef struct {
        int addr;
        int len;
        bit rand_ready;
        bit poke;
        int exp_first;
        int exp_hs;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        start         = 1'b0;
        m_axis_tready = 1'($urandom % 2);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'(pend_done));
        pend_done = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
    endtask

    task automatic run_burst(input int addr, input int len, input bit rr, input bit poke,
                             input int exp_first, input int exp_hs);
        int            first;
        int            hs;
        int            stab_err;
        int            busy_err;
        int            last_err;
        int            done_err;
        bit            stalled;
        logic [DW-1:0] pd;
        logic          pl;
        logic [DW-1:0] got[$];
        int            addrs[$];
        first = -1; hs = -1; stab_err = 0; busy_err = 0; last_err = 0; done_err = 0;
        stalled = 1'b0; pd = '0; pl = 1'b0;

        @(posedge clk);
        #1;
        start         = 1'b1;
        start_addr    = AW'(addr);
        length        = AW'(len);
        m_axis_tready = rr ? 1'($urandom % 2) : 1'b1;
        @(negedge clk);
        chk("c0_busy", 32'(busy), 32'd0);
        chk("c0_done", 32'(done), 32'(pend_done));
        pend_done = 1'b0;

        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            start = poke && (n == 2);
            if (start) begin
                start_addr = AW'(addr + 5);
                length     = AW'(len + 3);
            end
            m_axis_tready = rr ? 1'($urandom % 2) : 1'b1;
            @(negedge clk);
            if (busy !== 1'b1) busy_err++;
            if (done !== 1'b0) done_err++;
            if (ram_rd_en) addrs.push_back(int'(ram_rd_addr));
            if (m_axis_tvalid) begin
                if (first < 0) first = n;
                if (stalled && (m_axis_tdata !== pd || m_axis_tlast !== pl)) stab_err++;
                if (m_axis_tlast !== (got.size() == len)) last_err++;
                if (m_axis_tready) begin
                    got.push_back(m_axis_tdata);
                    stalled = 1'b0;
                    if (m_axis_tlast) hs = n;
                end else begin
                    stalled = 1'b1;
                    pd      = m_axis_tdata;
                    pl      = m_axis_tlast;
                end
            end else begin
                if (stalled) stab_err++;
                stalled = 1'b0;
            end
            if (hs >= 0) break;
        end
        start = 1'b0;

        if (hs < 0) begin
            checks++;
            failures++;
            $display("FAIL burst_timeout addr=%0d len=%0d actual=no_tlast required=tlast_handshake", addr, len);
        end
        chk("beat_count", 32'(got.size()), 32'(len + 1));
        for (int k = 0; k < got.size() && k <= len; k++)
            chk("beat_data", 32'(got[k]), 32'(mem[(addr + k) % DEPTH]));
        chk("addr_count", 32'(addrs.size()), 32'(len + 1));
        for (int k = 0; k < addrs.size() && k <= len; k++)
            chk("rd_addr", 32'(addrs[k]), 32'((addr + k) % DEPTH));
        chk("first_valid_cycle", 32'(first), 32'(exp_first));
        if (exp_hs >= 0) chk("tlast_cycle", 32'(hs), 32'(exp_hs));
        chk("stall_stability", 32'(stab_err), 32'd0);
        chk("busy_during_burst", 32'(busy_err), 32'd0);
        chk("tlast_position", 32'(last_err), 32'd0);
        chk("no_early_done", 32'(done_err), 32'd0);
        pend_done = 1'b1;
    endtask

    initial begin
        tbl[0] = '{addr: 4,  len: 3,  rand_ready: 1'b0, poke: 1'b0, exp_first: 3, exp_hs: 6};
        tbl[1] = '{addr: 14, len: 3,  rand_ready: 1'b0, poke: 1'b0, exp_first: 3, exp_hs: 6};
        tbl[2] = '{addr: 2,  len: 7,  rand_ready: 1'b1, poke: 1'b0, exp_first: 3, exp_hs: -1};
        tbl[3] = '{addr: 9,  len: 0,  rand_ready: 1'b0, poke: 1'b1, exp_first: 3, exp_hs: 3};
        tbl[4] = '{addr: 15, len: 1,  rand_ready: 1'b0, poke: 1'b0, exp_first: 3, exp_hs: 4};
        tbl[5] = '{addr: 0,  len: 15, rand_ready: 1'b1, poke: 1'b1, exp_first: 3, exp_hs: -1};

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        rstn = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_axis_tready = 1'b0;

        #23;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Directed table, back-to-back so each start lands in the done cycle
        for (int v = 0; v < 6; v++)
            run_burst(tbl[v].addr, tbl[v].len, tbl[v].rand_ready, tbl[v].poke,
                      tbl[v].exp_first, tbl[v].exp_hs);
        idle_cycle();

        // Random bursts over random RAM contents
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int r = 0; r < 20; r++) begin
            run_burst(int'($urandom_range(DEPTH - 1)), int'($urandom_range(DEPTH - 1)),
                      1'($urandom % 2), 1'($urandom % 2), 3, -1);
            if ($urandom % 2) idle_cycle();
        end
        idle_cycle();

        // Reset asserted mid-burst
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = AW'(4); length = AW'(7); m_axis_tready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn  = 1'b0;
        start = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("mid_rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        chk("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_start_ignored", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        start = 1'b0;
        pend_done = 1'b0;
        repeat (4) idle_cycle();
        run_burst(0, 1, 1'b0, 1'b0, 3, 4);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 1, meaning number of words in the attached RAM.
REQ-002 SHALL have parameter BYTE_WIDTH, default 1, meaning width of a RAM word and stream beat in bytes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 1, meaning width of RAM address, start_addr and length.
REQ-004 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock for all logic.
REQ-006 SHALL have port rstn, input, 1 bit, meaning the asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a burst read.
REQ-008 SHALL have port start_addr, input, ADDR_WIDTH bits, meaning the first RAM address of the burst.
REQ-009 SHALL have port length, input, ADDR_WIDTH bits, meaning the number of words minus one.
REQ-010 SHALL have port busy, output, 1 bit, meaning a burst is in progress.
REQ-011 SHALL have port done, output, 1 bit, meaning a one-cycle pulse at burst completion.
REQ-012 SHALL have port ram_rd_en, output, 1 bit, meaning the RAM read enable.
REQ-013 SHALL have port ram_rd_addr, output, ADDR_WIDTH bits, meaning the RAM read address.
REQ-014 SHALL have port ram_rd_data, input, BYTE_WIDTH*8 bits, meaning registered RAM data, valid one cycle after ram_rd_en.
REQ-015 SHALL have port m_axis_tdata, output, BYTE_WIDTH*8 bits, meaning the stream data.
REQ-016 SHALL have port m_axis_tvalid, output, 1 bit, meaning stream data valid.
REQ-017 SHALL have port m_axis_tready, input, 1 bit, meaning downstream accept.
REQ-018 SHALL have port m_axis_tlast, output, 1 bit, meaning this is the final beat of the burst.

Function
REQ-019 SHALL implement FSM states IDLE, READ and DRAIN: IDLE->READ on start; READ->DRAIN after the last read is issued; DRAIN->IDLE when the tlast beat handshakes.
REQ-020 SHALL latch start_addr and length on the cycle start is sampled high in IDLE; start SHALL be ignored when not in IDLE.
REQ-021 SHALL read exactly length+1 words, with length=0 meaning one word, from consecutive addresses.
REQ-022 SHALL wrap ram_rd_addr from RAM_DEPTH-1 to 0.
REQ-023 SHALL hold read data in a 2-entry output FIFO and SHALL assert ram_rd_en only when occupancy plus in-flight reads, minus any pop in the same cycle, is less than 2; no word SHALL be lost or duplicated.
REQ-024 SHALL capture ram_rd_data into the FIFO in the cycle after each ram_rd_en.
REQ-025 Latency: start high in cycle 0 -> ram_rd_en=1 with start_addr in cycle 1 -> m_axis_tvalid=1 in cycle 3.
REQ-026 SHALL sustain one beat per clk while m_axis_tready is held high.
REQ-027 SHALL keep m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while tvalid=1 and tready=0.
REQ-028 SHALL assert m_axis_tlast only with the (length+1)th beat.
REQ-029 SHALL keep busy=1 from the cycle after start is accepted until the tlast handshake cycle, inclusive.
REQ-030 SHALL pulse done for exactly one cycle after the tlast handshake, with busy=0 in that same cycle.
REQ-031 SHALL accept a new start in the cycle done is high.
REQ-032 SHALL hold ram_rd_addr at its last value when ram_rd_en=0.

Reset
REQ-033 SHALL, while rstn=0, drive busy, done, ram_rd_en, m_axis_tvalid and m_axis_tlast to 0, and ram_rd_addr and m_axis_tdata to 0.
REQ-034 SHALL, when reset asserts mid-burst, immediately return to IDLE, flush the FIFO, discard in-flight reads and not pulse done.
REQ-035 SHALL ignore start while rstn=0.

Verification
REQ-036 Bench SHALL cover: RAM[i]=i, start_addr=4, length=3, tready=1 -> beats 4,5,6,7 on consecutive cycles, tvalid first in cycle 3, tlast on 7, done one cycle later.
REQ-037 Bench SHALL cover: RAM_DEPTH=16, start_addr=14, length=3 -> addresses 14,15,0,1 and data in that order.
REQ-038 Bench SHALL cover: length=7, tready toggled randomly -> exactly 8 ordered beats, no drops or duplicates, data stable while stalled.
REQ-039 Bench SHALL cover: length=0 -> a single beat with tlast=1, and a start pulsed again while busy -> ignored.
REQ-040 Bench SHALL cover: rstn pulsed low mid-burst -> all outputs 0, no done pulse, and a following burst from address 0 with length=1 yields beats 0,1.
